// File: rtl/zigbee_tx_chip_modulator.sv
// 802.15.4 transmit chip generator: preamble, SFD and FIFO payload symbols are
// spread to 32-chip PN sequences and emitted with their MSK direction bit.
module zigbee_tx_chip_modulator #(
  parameter int          DATA_SIZE_BIT = 2,
  parameter int          PREAMBLE_SYMS = 8,
  parameter logic [7:0]  SFD_BYTE      = 8'hA7,
  parameter logic [31:0] CHIP_SEQ0     = 32'h744AC39B
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_chip_tick,
  input  logic                          i_start,
  input  logic [(2**DATA_SIZE_BIT)-1:0] i_fifo_data,
  input  logic                          i_fifo_empty,
  output logic                          o_fifo_rd,
  output logic                          o_chip,
  output logic                          o_dir,
  output logic                          o_chip_valid,
  output logic                          o_busy,
  output logic                          o_done
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SFD      = 2'd2,
    ST_PAYLOAD  = 2'd3
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_SYMS - 1);

  // Symbols 0..7 rotate seq0 by 4 chips each; 8..15 additionally invert odd chips.
  function automatic logic spread_chip(input logic [3:0] sym, input logic [4:0] idx);
    logic [4:0] pos;
    pos = idx - {sym[2:0], 2'b00};
    return CHIP_SEQ0[pos] ^ (sym[3] & idx[0]);
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  chip_idx_q, chip_idx_d;
  logic [7:0]  sym_cnt_q, sym_cnt_d;
  logic [3:0]  cur_sym_q, cur_sym_d;
  logic [3:0]  next_sym_q, next_sym_d;
  logic        more_q, more_d;
  logic        prev_chip_q, prev_chip_d;
  logic        cap_q, cap_d;
  logic        done_pend_q, done_pend_d;
  logic        chip_q, chip_d;
  logic        dir_q, dir_d;
  logic        valid_q, valid_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        chip_now_s;
  logic        prefetch_slot_s;

  // Next-state, chip emission and FIFO prefetch logic.
  always_comb begin
    state_d     = state_q;
    chip_idx_d  = chip_idx_q;
    sym_cnt_d   = sym_cnt_q;
    cur_sym_d   = cur_sym_q;
    more_d      = more_q;
    prev_chip_d = prev_chip_q;
    cap_d       = rd_q;
    done_pend_d = 1'b0;
    chip_d      = chip_q;
    dir_d       = dir_q;
    valid_d     = 1'b0;
    rd_d        = 1'b0;
    chip_now_s  = spread_chip(cur_sym_q, chip_idx_q);
    prefetch_slot_s = (state_q == ST_PAYLOAD) ||
                      ((state_q == ST_SFD) && (sym_cnt_q == 8'd0));

    // FIFO data is valid the cycle after the read pulse.
    if (cap_q) begin
      next_sym_d = 4'(i_fifo_data);
    end else begin
      next_sym_d = next_sym_q;
    end

    if (state_q == ST_IDLE) begin
      if (i_start && !i_fifo_empty) begin
        state_d     = ST_PREAMBLE;
        chip_idx_d  = 5'd0;
        sym_cnt_d   = 8'd0;
        cur_sym_d   = 4'h0;
        more_d      = 1'b0;
        prev_chip_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (i_chip_tick) begin
      chip_d      = chip_now_s;
      dir_d       = chip_now_s ^ prev_chip_q ^ chip_idx_q[0];
      prev_chip_d = chip_now_s;
      valid_d     = 1'b1;
      chip_idx_d  = chip_idx_q + 5'd1;

      if ((chip_idx_q == 5'd28) && prefetch_slot_s) begin
        if (!i_fifo_empty) begin
          rd_d   = 1'b1;
          more_d = 1'b1;
        end else begin
          more_d = 1'b0;
        end
      end else begin
        rd_d = 1'b0;
      end

      if (chip_idx_q == 5'd31) begin
        case (state_q)
          ST_PREAMBLE: begin
            if (sym_cnt_q == PRE_LAST) begin
              state_d   = ST_SFD;
              sym_cnt_d = 8'd0;
              cur_sym_d = SFD_BYTE[3:0];
            end else begin
              sym_cnt_d = sym_cnt_q + 8'd1;
              cur_sym_d = 4'h0;
            end
          end
          ST_SFD: begin
            if (sym_cnt_q == 8'd0) begin
              sym_cnt_d = 8'd1;
              cur_sym_d = SFD_BYTE[7:4];
            end else if (more_q) begin
              state_d   = ST_PAYLOAD;
              cur_sym_d = next_sym_q;
              more_d    = 1'b0;
            end else begin
              state_d     = ST_IDLE;
              done_pend_d = 1'b1;
            end
          end
          ST_PAYLOAD: begin
            if (more_q) begin
              cur_sym_d = next_sym_q;
              more_d    = 1'b0;
            end else begin
              state_d     = ST_IDLE;
              done_pend_d = 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end else begin
        cur_sym_d = cur_sym_q;
      end
    end else begin
      state_d = state_q;
    end

    // Busy covers the final chip's valid cycle; done follows one clock later.
    busy_d = (state_d != ST_IDLE) || (state_q != ST_IDLE);
    done_d = done_pend_q;
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      chip_idx_q  <= 5'd0;
      sym_cnt_q   <= 8'd0;
      cur_sym_q   <= 4'h0;
      next_sym_q  <= 4'h0;
      more_q      <= 1'b0;
      prev_chip_q <= 1'b0;
      cap_q       <= 1'b0;
      done_pend_q <= 1'b0;
      chip_q      <= 1'b0;
      dir_q       <= 1'b0;
      valid_q     <= 1'b0;
      rd_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chip_idx_q  <= chip_idx_d;
      sym_cnt_q   <= sym_cnt_d;
      cur_sym_q   <= cur_sym_d;
      next_sym_q  <= next_sym_d;
      more_q      <= more_d;
      prev_chip_q <= prev_chip_d;
      cap_q       <= cap_d;
      done_pend_q <= done_pend_d;
      chip_q      <= chip_d;
      dir_q       <= dir_d;
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_fifo_rd    = rd_q;
  assign o_chip       = chip_q;
  assign o_dir        = dir_q;
  assign o_chip_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_zigbee_tx_chip_modulator.sv
// Directed bench for zigbee_tx_chip_modulator: frames built from hand-computed
// symbol chip words, with a small FIFO model and a direction model.
module tb_zigbee_tx_chip_modulator;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_chip_tick = 1'b0;
  logic       i_start = 1'b0;
  logic [3:0] i_fifo_data = 4'h5;
  logic       i_fifo_empty = 1'b1;
  logic       o_fifo_rd, o_chip, o_dir, o_chip_valid, o_busy, o_done;

  zigbee_tx_chip_modulator dut (
    .i_clk(clk), .i_rst(i_rst), .i_chip_tick(i_chip_tick), .i_start(i_start),
    .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
    .o_fifo_rd(o_fifo_rd), .o_chip(o_chip), .o_dir(o_dir),
    .o_chip_valid(o_chip_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #10 clk = ~clk;

  // Hand-computed 32-chip words (bit i = chip i).
  localparam logic [31:0] W_SYM0 = 32'h744AC39B;
  localparam logic [31:0] W_SYM3 = 32'hAC39B744;
  localparam logic [31:0] W_SYM7 = 32'hB744AC39;
  localparam logic [31:0] W_SYM8 = 32'hDEE06931;
  localparam logic [31:0] W_SYMA = 32'hE06931DE;
  localparam logic [31:0] W_SYMF = 32'h1DEE0693;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc_no = 0;
  int          tick_div = 0;
  bit          chips[$];
  bit          dirs[$];
  int          rd_pos[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          last_valid_cyc = -1;
  int          busy_gap = 0;
  bit          in_frame = 1'b0;
  logic        busy_at_done = 1'b1;
  logic [3:0]  fifo_q[$];
  logic [3:0]  pend = 4'h0;
  bit          pend_v = 1'b0;
  logic [31:0] exp_syms[$];
  int          done0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive tick, advance, then sample outputs and model the FIFO.
  task automatic cycle();
    i_chip_tick = (tick_div == 0);
    tick_div = (tick_div == 24) ? 0 : tick_div + 1;
    @(posedge clk);
    #1;
    cyc_no++;
    i_fifo_data = pend_v ? pend : 4'h5;
    pend_v = 1'b0;
    if (o_chip_valid) begin
      chips.push_back(o_chip);
      dirs.push_back(o_dir);
      last_valid_cyc = cyc_no;
    end
    if (o_fifo_rd) begin
      rd_pos.push_back(int'(chips.size()) - 1);
      if (fifo_q.size() > 0) begin
        pend = fifo_q.pop_front();
        pend_v = 1'b1;
      end
    end
    i_fifo_empty = (fifo_q.size() == 0);
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc_no;
      busy_at_done = o_busy;
      in_frame = 1'b0;
    end else if (in_frame && !o_busy) begin
      busy_gap++;
    end
    i_start = 1'b0;
  endtask

  task automatic clear_rec();
    chips.delete();
    dirs.delete();
    rd_pos.delete();
    busy_gap = 0;
    done_cyc = -1;
    last_valid_cyc = -1;
    busy_at_done = 1'b1;
  endtask

  function automatic int rd_at(input int i);
    return (i < rd_pos.size()) ? rd_pos[i] : -1;
  endfunction

  task automatic run_frame(input int budget, input int mid_start, input int rst_at);
    int  d0;
    bit  mid_fired;
    d0 = done_cnt;
    mid_fired = 1'b0;
    clear_rec();
    i_start = 1'b1;
    in_frame = 1'b1;
    cycle();
    for (int c = 0; c < budget; c++) begin
      if (done_cnt != d0) break;
      if (rst_at >= 0 && chips.size() >= rst_at) begin
        i_rst = 1'b1;
        in_frame = 1'b0;
        #1;
        check_val("rst_mid_outs",
                  {26'd0, o_chip, o_dir, o_chip_valid, o_busy, o_done, o_fifo_rd}, 32'd0);
        repeat (3) cycle();
        i_rst = 1'b0;
        cycle();
        return;
      end
      if (mid_start >= 0 && !mid_fired && chips.size() >= mid_start) begin
        i_start = 1'b1;
        mid_fired = 1'b1;
      end
      cycle();
    end
    check_val("frame_done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_frame(input string pfx, input int n_reads);
    bit          exp_c[$];
    logic [31:0] act_c, act_d, exp_d;
    bit          prev;
    int          idx;
    foreach (exp_syms[s]) begin
      for (int i = 0; i < 32; i++) exp_c.push_back(exp_syms[s][i]);
    end
    check_val({pfx, "_nvalid"}, 32'(chips.size()), 32'(exp_c.size()));
    check_val({pfx, "_nreads"}, 32'(rd_pos.size()), 32'(n_reads));
    check_val({pfx, "_done_lag"}, 32'(done_cyc - last_valid_cyc), 32'd1);
    check_val({pfx, "_busy_gap"}, 32'(busy_gap), 32'd0);
    check_val({pfx, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
    prev = 1'b0;
    foreach (exp_syms[s]) begin
      act_c = 32'd0;
      act_d = 32'd0;
      exp_d = 32'd0;
      for (int i = 0; i < 32; i++) begin
        idx = s * 32 + i;
        exp_d[i] = exp_c[idx] ^ prev ^ idx[0];
        prev = exp_c[idx];
        if (idx < chips.size()) begin
          act_c[i] = chips[idx];
          act_d[i] = dirs[idx];
        end
      end
      check_val($sformatf("%s_sym%0d_chips", pfx, s), act_c, exp_syms[s]);
      check_val($sformatf("%s_sym%0d_dirs", pfx, s), act_d, exp_d);
    end
  endtask

  task automatic load_exp(input logic [31:0] pay0, input logic [31:0] pay1,
                          input logic [31:0] pay2, input int n_pay);
    exp_syms.delete();
    repeat (8) exp_syms.push_back(W_SYM0);
    exp_syms.push_back(W_SYM7);
    exp_syms.push_back(W_SYMA);
    if (n_pay > 0) exp_syms.push_back(pay0);
    if (n_pay > 1) exp_syms.push_back(pay1);
    if (n_pay > 2) exp_syms.push_back(pay2);
  endtask

  initial begin
    logic [7:0] first8;
    logic [3:0] first_dirs;

    repeat (3) cycle();
    check_val("reset_outs",
              {26'd0, o_chip, o_dir, o_chip_valid, o_busy, o_done, o_fifo_rd}, 32'd0);
    i_rst = 1'b0;

    // Ticks in IDLE produce nothing.
    clear_rec();
    repeat (100) cycle();
    check_val("idle_ticks_valid", 32'(chips.size()), 32'd0);
    check_val("idle_busy", {31'd0, o_busy}, 32'd0);

    // Start with an empty FIFO is ignored.
    i_start = 1'b1;
    cycle();
    repeat (100) cycle();
    check_val("empty_start_busy", {31'd0, o_busy}, 32'd0);
    check_val("empty_start_valid", 32'(chips.size()), 32'd0);
    check_val("empty_start_reads", 32'(rd_pos.size()), 32'd0);

    // Frame 1: payload {3}, with a stray start mid-preamble.
    fifo_q.delete();
    fifo_q.push_back(4'h3);
    i_fifo_empty = 1'b0;
    run_frame(12000, 50, -1);
    load_exp(W_SYM3, 32'd0, 32'd0, 1);
    check_frame("f1", 1);
    first8 = 8'd0;
    first_dirs = 4'd0;
    for (int i = 0; i < 8; i++) if (i < chips.size()) first8[i] = chips[i];
    for (int i = 0; i < 4; i++) if (i < dirs.size()) first_dirs[i] = dirs[i];
    check_val("f1_first8_chips", {24'd0, first8}, 32'h9B);
    check_val("f1_first4_dirs", {28'd0, first_dirs}, 32'h7);
    check_val("f1_sym7_chip0", (chips.size() > 256) ? {31'd0, chips[256]} : 32'hDEAD, 32'd1);
    check_val("f1_symA_chip1", (chips.size() > 289) ? {31'd0, chips[289]} : 32'hDEAD, 32'd1);
    check_val("f1_rd0_pos", 32'(rd_at(0)), 32'd284);
    repeat (60) cycle();
    check_val("f1_idle_after", {31'd0, o_busy}, 32'd0);
    check_val("f1_no_restart", 32'(chips.size()), 32'd352);

    // Frame 2: payload {0, F, 8}, reads at chip 28 of SFD0, sym0, symF.
    fifo_q.delete();
    fifo_q.push_back(4'h0);
    fifo_q.push_back(4'hF);
    fifo_q.push_back(4'h8);
    i_fifo_empty = 1'b0;
    run_frame(13000, -1, -1);
    load_exp(W_SYM0, W_SYMF, W_SYM8, 3);
    check_frame("f2", 3);
    check_val("f2_rd0_pos", 32'(rd_at(0)), 32'd284);
    check_val("f2_rd1_pos", 32'(rd_at(1)), 32'd348);
    check_val("f2_rd2_pos", 32'(rd_at(2)), 32'd380);

    // Reset mid-frame at chip 100, then a clean replay.
    fifo_q.delete();
    fifo_q.push_back(4'h3);
    i_fifo_empty = 1'b0;
    done0 = done_cnt;
    run_frame(5000, -1, 100);
    clear_rec();
    repeat (300) cycle();
    check_val("rst_no_done", 32'(done_cnt - done0), 32'd0);
    check_val("rst_no_valid_after", 32'(chips.size()), 32'd0);
    check_val("rst_fifo_untouched", 32'(fifo_q.size()), 32'd1);
    run_frame(12000, -1, -1);
    load_exp(W_SYM3, 32'd0, 32'd0, 1);
    check_frame("f3", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
